// File: rtl/vc_sched_pkg.sv
// Shared definitions for the weighted round-robin VC scheduler:
// one-hot FSM states, VC index constants and default widths.
package vc_sched_pkg;
  localparam int DATA_W_DEF   = 6;
  localparam int WEIGHT_W_DEF = 2;

  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;

  typedef enum logic [3:0] {
    ST_INIT   = 4'b0001,
    ST_IDLE   = 4'b0010,
    ST_ACTIVE = 4'b0100,
    ST_ERROR  = 4'b1000
  } state_t;
endpackage

// File: rtl/vc_scheduler_if.sv
// Bus between the VC FIFO stage, the destination FIFO stage and the scheduler.
// VC_SCHED_STATS_EN adds the per-VC pop counters.
interface vc_scheduler_if import vc_sched_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF
);
  logic                init;
  logic [WEIGHT_W-1:0] weight_vc0;
  logic [WEIGHT_W-1:0] weight_vc1;
  logic                vc0_empty;
  logic [DATA_W-1:0]   vc0_data;
  logic                vc0_pop;
  logic                vc1_empty;
  logic [DATA_W-1:0]   vc1_data;
  logic                vc1_pop;
  logic                d0_almost_full;
  logic                d1_almost_full;
  logic                d0_push;
  logic                d1_push;
  logic [DATA_W-1:0]   d_data;
  logic                idle_out;
  logic                active_out;
  logic                error_out;
`ifdef VC_SCHED_STATS_EN
  logic [7:0]          cnt_vc0;
  logic [7:0]          cnt_vc1;
`endif

  modport master (
    output init, weight_vc0, weight_vc1, vc0_empty, vc0_data, vc1_empty, vc1_data,
           d0_almost_full, d1_almost_full,
    input  vc0_pop, vc1_pop, d0_push, d1_push, d_data, idle_out, active_out, error_out
`ifdef VC_SCHED_STATS_EN
    , input cnt_vc0, cnt_vc1
`endif
  );

  modport slave (
    input  init, weight_vc0, weight_vc1, vc0_empty, vc0_data, vc1_empty, vc1_data,
           d0_almost_full, d1_almost_full,
    output vc0_pop, vc1_pop, d0_push, d1_push, d_data, idle_out, active_out, error_out
`ifdef VC_SCHED_STATS_EN
    , output cnt_vc0, cnt_vc1
`endif
  );
endinterface

// File: rtl/vc_wrr_pick.sv
// Combinational grant selection and next cur/credit for the WRR scheduler.
// The current VC is served while it has credit; a blocked-but-nonempty current
// VC lends the slot to the other VC without losing its turn.
module vc_wrr_pick import vc_sched_pkg::*; #(
  parameter int WEIGHT_W = WEIGHT_W_DEF
) (
  input  logic                i_active,
  input  logic                i_cur,
  input  logic [WEIGHT_W-1:0] i_credit,
  input  logic [WEIGHT_W-1:0] i_w0,
  input  logic [WEIGHT_W-1:0] i_w1,
  input  logic                i_vc0_empty,
  input  logic                i_vc1_empty,
  input  logic                i_vc0_msb,
  input  logic                i_vc1_msb,
  input  logic                i_d0_af,
  input  logic                i_d1_af,
  output logic                o_gnt0,
  output logic                o_gnt1,
  output logic                o_cur_nxt,
  output logic [WEIGHT_W-1:0] o_credit_nxt
);
  logic                w_en0, w_en1, w_elig0, w_elig1;
  logic                w_cur_elig, w_oth_elig, w_cur_en, w_oth_en, w_cur_empty;
  logic                w_gnt_cur, w_gnt_oth;
  logic [WEIGHT_W-1:0] w_cur_w, w_oth_w, w_crd_dec;

  assign w_en0   = (i_w0 != '0);
  assign w_en1   = (i_w1 != '0);
  // destination is chosen by the head word's MSB, so backpressure is per head
  assign w_elig0 = w_en0 && !i_vc0_empty && !(i_vc0_msb ? i_d1_af : i_d0_af);
  assign w_elig1 = w_en1 && !i_vc1_empty && !(i_vc1_msb ? i_d1_af : i_d0_af);

  assign w_cur_elig  = (i_cur == VC1) ? w_elig1 : w_elig0;
  assign w_oth_elig  = (i_cur == VC1) ? w_elig0 : w_elig1;
  assign w_cur_en    = (i_cur == VC1) ? w_en1 : w_en0;
  assign w_oth_en    = (i_cur == VC1) ? w_en0 : w_en1;
  assign w_cur_empty = (i_cur == VC1) ? i_vc1_empty : i_vc0_empty;
  assign w_cur_w     = (i_cur == VC1) ? i_w1 : i_w0;
  assign w_oth_w     = (i_cur == VC1) ? i_w0 : i_w1;

  assign w_gnt_cur = i_active && w_cur_elig;
  assign w_gnt_oth = i_active && !w_cur_elig && w_oth_elig;
  assign o_gnt0    = (i_cur == VC0) ? w_gnt_cur : w_gnt_oth;
  assign o_gnt1    = (i_cur == VC1) ? w_gnt_cur : w_gnt_oth;

  assign w_crd_dec = (i_credit != '0) ? i_credit - WEIGHT_W'(1) : '0;

  // credit/cur update: turn ends on exhausted credit or an empty/disabled cur
  always_comb begin
    o_cur_nxt    = i_cur;
    o_credit_nxt = i_credit;
    if (i_active) begin
      if (w_gnt_cur) begin
        o_credit_nxt = w_crd_dec;
        if (w_crd_dec == '0) begin
          o_cur_nxt    = w_oth_en ? ~i_cur : i_cur;
          o_credit_nxt = w_oth_en ? w_oth_w : w_cur_w;
        end
      end else if (w_cur_empty || !w_cur_en) begin
        o_cur_nxt    = w_oth_en ? ~i_cur : i_cur;
        o_credit_nxt = w_oth_en ? w_oth_w : w_cur_w;
      end
    end
  end
endmodule

// File: rtl/vc_scheduler.sv
// Weighted round-robin scheduler draining VC0/VC1 into D0/D1.
// Pop is combinational in the grant cycle; the word is pushed one cycle later.
// Optional macro VC_SCHED_STATS_EN adds saturating 8-bit pop counters.
module vc_scheduler import vc_sched_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  vc_scheduler_if.slave bus
);
  state_t              r_state, w_state_nxt;
  logic [WEIGHT_W-1:0] r_w0, r_w1, r_credit, w_credit_nxt, w_init_credit;
  logic                r_cur, w_cur_nxt, w_init_cur, w_init_err;
  logic                r_error, r_d0_push, r_d1_push;
  logic [DATA_W-1:0]   r_d_data;
  logic                w_active, w_any_ready, w_gnt0, w_gnt1;

  assign w_active      = (r_state == ST_ACTIVE);
  assign w_init_err    = (bus.weight_vc0 == '0) && (bus.weight_vc1 == '0);
  assign w_init_cur    = (bus.weight_vc0 != '0) ? VC0 : VC1;
  assign w_init_credit = (bus.weight_vc0 != '0) ? bus.weight_vc0 : bus.weight_vc1;
  assign w_any_ready   = ((r_w0 != '0) && !bus.vc0_empty) || ((r_w1 != '0) && !bus.vc1_empty);

  vc_wrr_pick #(.WEIGHT_W(WEIGHT_W)) u_pick (
    .i_active    (w_active),
    .i_cur       (r_cur),
    .i_credit    (r_credit),
    .i_w0        (r_w0),
    .i_w1        (r_w1),
    .i_vc0_empty (bus.vc0_empty),
    .i_vc1_empty (bus.vc1_empty),
    .i_vc0_msb   (bus.vc0_data[DATA_W-1]),
    .i_vc1_msb   (bus.vc1_data[DATA_W-1]),
    .i_d0_af     (bus.d0_almost_full),
    .i_d1_af     (bus.d1_almost_full),
    .o_gnt0      (w_gnt0),
    .o_gnt1      (w_gnt1),
    .o_cur_nxt   (w_cur_nxt),
    .o_credit_nxt(w_credit_nxt)
  );

  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;

  // next state; init overrides from any state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:   w_state_nxt = ST_INIT;
      ST_IDLE:   if (w_any_ready) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!w_any_ready && !r_d0_push && !r_d1_push) w_state_nxt = ST_IDLE;
      ST_ERROR:  w_state_nxt = ST_ERROR;
      default:   w_state_nxt = ST_INIT;
    endcase
    if (bus.init) w_state_nxt = w_init_err ? ST_ERROR : ST_IDLE;
  end

  // weights, turn pointer, credit and sticky error
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_w0 <= '0; r_w1 <= '0; r_credit <= '0; r_cur <= VC0; r_error <= 1'b0;
    end else if (bus.init) begin
      r_w0 <= bus.weight_vc0; r_w1 <= bus.weight_vc1;
      r_cur <= w_init_cur; r_credit <= w_init_credit; r_error <= w_init_err;
    end else begin
      r_cur <= w_cur_nxt; r_credit <= w_credit_nxt;
    end

  // output register: granted head word lands in D0/D1 one cycle later
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_d0_push <= 1'b0; r_d1_push <= 1'b0; r_d_data <= '0;
    end else begin
      r_d0_push <= (w_gnt0 && !bus.vc0_data[DATA_W-1]) || (w_gnt1 && !bus.vc1_data[DATA_W-1]);
      r_d1_push <= (w_gnt0 &&  bus.vc0_data[DATA_W-1]) || (w_gnt1 &&  bus.vc1_data[DATA_W-1]);
      if (w_gnt0)      r_d_data <= bus.vc0_data;
      else if (w_gnt1) r_d_data <= bus.vc1_data;
    end

  assign bus.vc0_pop    = w_gnt0;
  assign bus.vc1_pop    = w_gnt1;
  assign bus.d0_push    = r_d0_push;
  assign bus.d1_push    = r_d1_push;
  assign bus.d_data     = r_d_data;
  assign bus.idle_out   = (r_state == ST_IDLE);
  assign bus.active_out = w_active;
  assign bus.error_out  = r_error;

`ifdef VC_SCHED_STATS_EN
  logic [7:0] r_cnt0, r_cnt1;

  // saturating pop counters, cleared on init
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt0 <= '0; r_cnt1 <= '0;
    end else if (bus.init) begin
      r_cnt0 <= '0; r_cnt1 <= '0;
    end else begin
      if (w_gnt0 && r_cnt0 != 8'hFF) r_cnt0 <= r_cnt0 + 8'd1;
      if (w_gnt1 && r_cnt1 != 8'hFF) r_cnt1 <= r_cnt1 + 8'd1;
    end

  assign bus.cnt_vc0 = r_cnt0;
  assign bus.cnt_vc1 = r_cnt1;
`endif
endmodule

// File: tb/tb_vc_scheduler.sv
// Directed bench for vc_scheduler: VC FIFOs are modelled as queues,
// a table covers first-grant decisions, hand sequences cover the multi-cycle cases.
module tb_vc_scheduler;
  localparam int DW = 6;
  localparam int WW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_scheduler_if #(.DATA_W(DW), .WEIGHT_W(WW)) bus();
  vc_scheduler #(.DATA_W(DW), .WEIGHT_W(WW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic s_pop0, s_pop1, s_push0, s_push1, s_idle, s_active, s_error;
  logic [DW-1:0] s_data, s_h0, s_h1;
  logic prev_pop, lat_en;
  logic [DW-1:0] prev_data;

  typedef struct {
    logic [WW-1:0] w0, w1;
    logic e0, e1, m0, m1, af0, af1;
    logic x_idle, x_act, x_err, x_p0, x_p1;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive_fifo();
    bus.vc0_empty = (q0.size() == 0);
    bus.vc0_data  = (q0.size() != 0) ? q0[0] : '0;
    bus.vc1_empty = (q1.size() == 0);
    bus.vc1_data  = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // one clock: drive heads after negedge, sample, let the edge pop the queues
  task automatic cycle();
    drive_fifo();
    #1;
    s_pop0 = bus.vc0_pop;  s_pop1 = bus.vc1_pop;
    s_push0 = bus.d0_push; s_push1 = bus.d1_push; s_data = bus.d_data;
    s_idle = bus.idle_out; s_active = bus.active_out; s_error = bus.error_out;
    s_h0 = bus.vc0_data;   s_h1 = bus.vc1_data;
    if (lat_en) begin
      check("one_pop", int'(s_pop0 & s_pop1), 0);
      check("push_dest", int'({s_push1, s_push0}), prev_pop ? (prev_data[DW-1] ? 2 : 1) : 0);
      if (prev_pop) check("push_data", int'(s_data), int'(prev_data));
    end
    prev_pop  = s_pop0 | s_pop1;
    prev_data = s_pop0 ? s_h0 : s_h1;
    @(posedge clk);
    if (s_pop0 && q0.size() != 0) void'(q0.pop_front());
    if (s_pop1 && q1.size() != 0) void'(q1.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.init = 1'b0;
    reset = 1'b1;
    q0.delete(); q1.delete();
    drive_fifo();
    prev_pop = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic init_pulse(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
    bus.weight_vc0 = w0; bus.weight_vc1 = w1; bus.init = 1'b1;
    cycle();
    bus.init = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[12];
    int npop, nbad, npush0, npush1;
    logic started;

    // w0 w1  e0 e1 m0 m1 af0 af1 | idle act err p0 p1
    tbl[0] = '{2'd1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    tbl[1] = '{2'd1, 2'd1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[2] = '{2'd1, 2'd1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1};
    tbl[3] = '{2'd1, 2'd1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0};
    tbl[4] = '{2'd0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[5] = '{2'd1, 2'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[6] = '{2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[7] = '{2'd2, 2'd1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1};
    tbl[8] = '{2'd3, 2'd1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0};
    exp_seq = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};

    bus.init = 1'b0; bus.weight_vc0 = '0; bus.weight_vc1 = '0;
    bus.d0_almost_full = 1'b0; bus.d1_almost_full = 1'b0;
    lat_en = 1'b0; prev_pop = 1'b0; prev_data = '0;
    reset = 1'b1;
    drive_fifo();
    #2;
    // reset state
    check("rst_idle", int'(bus.idle_out), 0);
    check("rst_active", int'(bus.active_out), 0);
    check("rst_error", int'(bus.error_out), 0);
    check("rst_push", int'({bus.d1_push, bus.d0_push}), 0);
    check("rst_data", int'(bus.d_data), 0);
    @(negedge clk);
    reset = 1'b0;

    // first-grant table
    foreach (tbl[k]) begin
      do_reset();
      bus.d0_almost_full = tbl[k].af0;
      bus.d1_almost_full = tbl[k].af1;
      for (int j = 0; j < 4; j++) begin
        if (!tbl[k].e0) q0.push_back({tbl[k].m0, 5'(j)});
        if (!tbl[k].e1) q1.push_back({tbl[k].m1, 5'(j + 8)});
      end
      init_pulse(tbl[k].w0, tbl[k].w1);
      cycle();
      drive_fifo();
      #1;
      check($sformatf("v%0d_idle", k),   int'(bus.idle_out),   int'(tbl[k].x_idle));
      check($sformatf("v%0d_active", k), int'(bus.active_out), int'(tbl[k].x_act));
      check($sformatf("v%0d_error", k),  int'(bus.error_out),  int'(tbl[k].x_err));
      check($sformatf("v%0d_pop0", k),   int'(bus.vc0_pop),    int'(tbl[k].x_p0));
      check($sformatf("v%0d_pop1", k),   int'(bus.vc1_pop),    int'(tbl[k].x_p1));
      @(negedge clk);
    end
    bus.d0_almost_full = 1'b0; bus.d1_almost_full = 1'b0;

    // weights 2/1, six words each to D0
    do_reset();
    lat_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      q0.push_back(6'(i));
      q1.push_back(6'(16 + i));
    end
    init_pulse(2'd2, 2'd1);
    npop = 0; nbad = 0; npush0 = 0; npush1 = 0; started = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (s_pop0 | s_pop1) begin
        if (npop < 12) check($sformatf("wrr_pop%0d", npop), int'(s_pop1), exp_seq[npop]);
        npop++;
        started = 1'b1;
      end
      if (s_push0) npush0++;
      if (s_push1) npush1++;
      if (started && s_idle) break;
      if (started && !s_active) nbad++;
    end
    check("wrr_npop", npop, 12);
    check("wrr_npush0", npush0, 12);
    check("wrr_npush1", npush1, 0);
    check("wrr_active_gap", nbad, 0);
    check("wrr_idle_end", int'(s_idle), 1);

    // weights 1/1: VC0 blocked on D1, VC1 served; VC0 resumes with its turn intact
    do_reset();
    lat_en = 1'b1;
    for (int i = 0; i < 3; i++) q0.push_back(6'(32 + i));
    for (int i = 0; i < 6; i++) q1.push_back(6'(1 + i));
    bus.d1_almost_full = 1'b1;
    init_pulse(2'd1, 2'd1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("bp_stall%0d", i), int'({s_pop1, s_pop0}), 2);
    end
    bus.d1_almost_full = 1'b0;
    cycle(); check("bp_resume0", int'({s_pop1, s_pop0}), 1);
    cycle(); check("bp_resume1", int'({s_pop1, s_pop0}), 2);
    cycle(); check("bp_resume2", int'({s_pop1, s_pop0}), 1);
    cycle();

    // configuration error and single-VC enable
    do_reset();
    lat_en = 1'b0;
    q0.push_back(6'd3); q1.push_back(6'd4);
    init_pulse(2'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("err_flag%0d", i), int'(s_error), 1);
      check($sformatf("err_nopop%0d", i), int'({s_pop1, s_pop0}), 0);
    end
    q0.delete();
    init_pulse(2'd1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("vc1off_err%0d", i), int'(s_error), 0);
      check($sformatf("vc1off_idle%0d", i), int'(s_idle), 1);
      check($sformatf("vc1off_pop%0d", i), int'({s_pop1, s_pop0}), 0);
    end

    // reset with a word in flight
    do_reset();
    lat_en = 1'b0;
    q0.push_back(6'd1); q0.push_back(6'd2);
    q1.push_back(6'd3); q1.push_back(6'd4);
    init_pulse(2'd1, 2'd1);
    cycle();
    cycle();
    check("rip_first_pop", int'({s_pop1, s_pop0}), 1);
    check("rip_push_live", int'(bus.d0_push), 1);
    reset = 1'b1;
    #1;
    check("rip_push", int'({bus.d1_push, bus.d0_push}), 0);
    check("rip_data", int'(bus.d_data), 0);
    check("rip_state", int'({bus.error_out, bus.active_out, bus.idle_out}), 0);
    check("rip_pop", int'({bus.vc1_pop, bus.vc0_pop}), 0);
    @(negedge clk);
    reset = 1'b0;
    prev_pop = 1'b0;
    init_pulse(2'd1, 2'd1);
    cycle();
    cycle();
    check("rip_restart_pop", int'({s_pop1, s_pop0}), 1);
    check("rip_restart_head", int'(s_h0), 2);

    // weights 3/3, only VC1 has data
    do_reset();
    lat_en = 1'b1;
    for (int i = 0; i < 8; i++) q1.push_back(6'(40 + i));
    init_pulse(2'd3, 2'd3);
    cycle();
    for (int i = 0; i < 8; i++) begin
      cycle();
      check($sformatf("vc1only_pop%0d", i), int'({s_pop1, s_pop0}), 2);
    end
    cycle();

`ifdef VC_SCHED_STATS_EN
    // counter saturation
    do_reset();
    lat_en = 1'b0;
    for (int i = 0; i < 300; i++) q0.push_back(6'(i % 32));
    init_pulse(2'd1, 2'd0);
    npop = 0;
    for (int c = 0; c < 400 && q0.size() != 0; c++) begin
      cycle();
      if (s_pop0) npop++;
    end
    cycle();
    check("stats_npop", npop, 300);
    check("stats_cnt0", int'(bus.cnt_vc0), 255);
    check("stats_cnt1", int'(bus.cnt_vc1), 0);
    init_pulse(2'd1, 2'd0);
    check("stats_clear", int'(bus.cnt_vc0), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vc_scheduler.md
Name: vc_scheduler

Overview:
- Weighted round-robin scheduler that drains the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1).
- The destination of each word comes from its MSB.
- Sits between the VC FIFO stage and the destination FIFO stage, downstream of control_fsm.
- Sequences all pops and pushes between the two stages, and reports idle/active/error status.

Parameters:
- DATA_W, 6: word width; bit DATA_W-1 selects the destination (0 = D0, 1 = D1).
- WEIGHT_W, 2: width of each VC weight/credit field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- init  in  1  one-cycle pulse; latches the weights and (re)starts scheduling.
- weight_vc0  in  WEIGHT_W  VC0 words per turn; 0 = VC0 disabled.
- weight_vc1  in  WEIGHT_W  VC1 words per turn; 0 = VC1 disabled.
- vc0_empty  in  1  VC0 FIFO empty.
- vc0_data  in  DATA_W  VC0 head word (first-word-fall-through).
- vc0_pop  out  1  pop VC0 this cycle.
- vc1_empty  in  1  VC1 FIFO empty.
- vc1_data  in  DATA_W  VC1 head word (first-word-fall-through).
- vc1_pop  out  1  pop VC1 this cycle.
- d0_almost_full  in  1  D0 has at most one free slot.
- d1_almost_full  in  1  D1 has at most one free slot.
- d0_push  out  1  push d_data into D0.
- d1_push  out  1  push d_data into D1.
- d_data  out  DATA_W  word being pushed.
- idle_out  out  1  in IDLE.
- active_out  out  1  in ACTIVE.
- error_out  out  1  configuration error; sticky.

Behaviour:
- Reset (asynchronous, active-high):
  - state = INIT; w0, w1, credit = 0; cur = VC0.
  - d0_push, d1_push, d_data, error_out = 0; an in-flight word is dropped.
  - vc0_pop and vc1_pop are 0 while reset is asserted.
- States are one-hot: INIT, IDLE, ACTIVE, ERROR.
- INIT:
  - All outputs except error_out are 0.
  - On init=1: latch w0/w1 from the weight inputs.
  - If both weights are 0, go to ERROR.
  - Otherwise go to IDLE with cur = first enabled VC (VC0 preferred) and credit = its weight.
- IDLE:
  - idle_out = 1.
  - Go to ACTIVE when any enabled VC has empty = 0.
- ACTIVE:
  - active_out = 1.
  - Go to IDLE when every enabled VC is empty and no push is pending.
- ERROR:
  - error_out = 1 and stays set until reset or init.
  - init with at least one weight nonzero returns to IDLE and clears error_out.
  - init with both weights 0 stays in ERROR.
- init in IDLE/ACTIVE: reloads the weights and credit exactly as in INIT. A push already launched still completes.
- Eligibility: a VC is eligible when it is enabled, its empty flag is 0, and the almost_full flag of the destination selected by its head MSB is 0.
- Grant, combinational, in ACTIVE only:
  - If cur is eligible, grant cur and decrement credit.
  - Otherwise, if the other VC is eligible, grant it. Work-conserving: credit is unchanged and cur does not switch.
  - Otherwise no grant.
- Switch rule: when credit reaches 0 after a grant, or cur is empty or disabled, set cur = other enabled VC and credit = its weight. With a single enabled VC, cur stays put and credit reloads.
- At most one pop per cycle. vcX_pop = grant to VCX, asserted in the same cycle as the grant.
- Latency is 1 cycle: the granted head word is registered into d_data, and the matching dX_push asserts in the next cycle for exactly one cycle.
- d_data holds its last value when no push is asserted.
- Almost_full means one free slot. The in-flight word may therefore land after the flag rises; no overflow is possible.
- Simultaneous pop and the VC going empty: the empty flag is sampled in the next cycle, with no lookahead.
- Credit arithmetic: unsigned WEIGHT_W bits, never decremented below 0.

Optional Feature:
- Macro VC_SCHED_STATS_EN.
- When defined:
  - Adds outputs cnt_vc0 and cnt_vc1, 8 bits each.
  - Each counts that VC's pops.
  - Counters saturate at 255, clear on reset, and clear on init.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package vc_sched_pkg holds:
  - one-hot state constants INIT/IDLE/ACTIVE/ERROR;
  - the VC index constants;
  - default DATA_W and WEIGHT_W.
- Sub-module vc_wrr_pick: combinational grant selection plus next-cur/next-credit computation.
- The top level keeps the FSM, the output register and the optional stats.

Test Plan:
- Weights 2/1, both VCs pre-filled with 6 words to D0, no backpressure -> pop order VC0,VC0,VC1 repeated; each push one cycle after its pop; active_out high throughout, then idle_out.
- Weights 1/1, VC0 head destined to D1 with d1_almost_full=1 and VC1 head to D0 -> VC1 served each cycle and VC0 stalled; when d1_almost_full drops, VC0 resumes with credit intact.
- init with weights 0/0 -> ERROR, error_out=1, no pops; init with 1/0 -> IDLE, error_out=0, VC1 never popped even when non-empty.
- Reset asserted one cycle after a pop -> push suppressed, all outputs 0 immediately, state INIT; a fresh init restarts with cur=VC0.
- Weights 3/3, VC1 only non-empty -> VC1 popped every cycle, credit reloads and cur switches correctly.
- With VC_SCHED_STATS_EN defined: 300 pops from VC0 -> cnt_vc0=255.
